// File: rtl/rx_link_pkg.sv
// rtl/rx_link_pkg.sv - shared constants and types for the fiber RX/TX link
package rx_link_pkg;

    localparam logic [7:0] K28_5_COMMA  = 8'hBC;
    localparam logic [7:0] K28_0_MARKER = 8'h1C;

    typedef enum logic [1:0] {
        CLS_COMMA  = 2'd0,
        CLS_MARKER = 2'd1,
        CLS_DATA   = 2'd2,
        CLS_ERROR  = 2'd3
    } word_class_t;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_LOCKING  = 2'd1,
        ST_LOCKED   = 2'd2
    } link_state_t;

    // Only a K on the low byte is legal; the low byte then names the control code.
    function automatic word_class_t classify_word(input logic [15:0] data,
                                                  input logic [1:0]  kchar);
        word_class_t cls;
        cls = CLS_ERROR;
        if (kchar == 2'b00) begin
            cls = CLS_DATA;
        end else if (kchar == 2'b01) begin
            if (data[7:0] == K28_5_COMMA) begin
                cls = CLS_COMMA;
            end else if (data[7:0] == K28_0_MARKER) begin
                cls = CLS_MARKER;
            end
        end
        return cls;
    endfunction

endpackage

// File: rtl/rx_word_classify.sv
// rtl/rx_word_classify.sv - stage-1 register of the RX word and mode bits, plus class decode
module rx_word_classify
    import rx_link_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] rx_data,
    input  logic [1:0]  rx_kchar,
    input  logic        prbs_en,
    input  logic        marker_en,
    output logic [15:0] s1_data,
    output logic [1:0]  s1_kchar,
    output logic        s1_prbs_en,
    output logic        s1_marker_en,
    output word_class_t s1_class
);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_data      <= '0;
            s1_kchar     <= '0;
            s1_prbs_en   <= 1'b0;
            s1_marker_en <= 1'b0;
        end else begin
            s1_data      <= rx_data;
            s1_kchar     <= rx_kchar;
            s1_prbs_en   <= prbs_en;
            s1_marker_en <= marker_en;
        end
    end

    assign s1_class = classify_word(s1_data, s1_kchar);

endmodule

// File: rtl/demux_rx.sv
// rtl/demux_rx.sv - RX word demultiplexer with comma-based link lock and marker/error counters
module demux_rx
    import rx_link_pkg::*;
#(
    parameter int unsigned LOCK_CNT  = 16,
    parameter int unsigned ERR_LIMIT = 4
)
(
    input  logic        RX_CLK,
    input  logic        RESET,
    input  logic [15:0] RX_DATA,
    input  logic [1:0]  RX_KCHAR,
    input  logic        PRBS_EN,
    input  logic        MARKER_EN,
    input  logic        CLR_CNT,
    output logic [15:0] PRBS_DATA,
    output logic [1:0]  PRBS_KCHAR,
    output logic        PRBS_VALID,
    output logic [15:0] FIBER_DATA,
    output logic [1:0]  FIBER_KCHAR,
    output logic        FIBER_VALID,
    output logic        MARKER_SEEN,
    output logic [7:0]  MARKER_DATA,
    output logic        LOCKED,
    output logic [15:0] ERR_CNT,
    output logic [15:0] MARKER_CNT
);

    localparam logic [7:0] LOCK_TGT = 8'(LOCK_CNT);
    localparam logic [3:0] ERR_TGT  = 4'(ERR_LIMIT);

    logic [15:0] s1_data;
    logic [1:0]  s1_kchar;
    logic        s1_prbs_en;
    logic        s1_marker_en;
    word_class_t s1_class;

    link_state_t state, state_nxt;
    logic [7:0]  lock_run, lock_run_nxt;
    logic [3:0]  err_run, err_run_nxt;
    logic [15:0] err_cnt_r, marker_cnt_r;

    logic fiber_ok, marker_hit, err_hit;

    rx_word_classify u_classify (
        .clk          (RX_CLK),
        .reset        (RESET),
        .rx_data      (RX_DATA),
        .rx_kchar     (RX_KCHAR),
        .prbs_en      (PRBS_EN),
        .marker_en    (MARKER_EN),
        .s1_data      (s1_data),
        .s1_kchar     (s1_kchar),
        .s1_prbs_en   (s1_prbs_en),
        .s1_marker_en (s1_marker_en),
        .s1_class     (s1_class)
    );

    always_ff @(posedge RX_CLK) begin
        if (RESET) begin
            state    <= ST_UNLOCKED;
            lock_run <= '0;
            err_run  <= '0;
        end else begin
            state    <= state_nxt;
            lock_run <= lock_run_nxt;
            err_run  <= err_run_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        lock_run_nxt = lock_run;
        err_run_nxt  = err_run;
        if (s1_prbs_en) begin
            state_nxt    = ST_UNLOCKED;
            lock_run_nxt = '0;
            err_run_nxt  = '0;
        end else begin
            case (state)
                ST_UNLOCKED: begin
                    lock_run_nxt = '0;
                    err_run_nxt  = '0;
                    if (s1_class == CLS_COMMA) begin
                        if (LOCK_TGT == 8'd1) begin
                            state_nxt = ST_LOCKED;
                        end else begin
                            state_nxt    = ST_LOCKING;
                            lock_run_nxt = 8'd1;
                        end
                    end
                end
                ST_LOCKING: begin
                    if (s1_class == CLS_COMMA) begin
                        if (lock_run + 8'd1 == LOCK_TGT) begin
                            state_nxt    = ST_LOCKED;
                            lock_run_nxt = '0;
                        end else begin
                            lock_run_nxt = lock_run + 8'd1;
                        end
                    end else begin
                        state_nxt    = ST_UNLOCKED;
                        lock_run_nxt = '0;
                    end
                end
                ST_LOCKED: begin
                    if (s1_class == CLS_ERROR) begin
                        if (err_run + 4'd1 == ERR_TGT) begin
                            state_nxt   = ST_UNLOCKED;
                            err_run_nxt = '0;
                        end else begin
                            err_run_nxt = err_run + 4'd1;
                        end
                    end else begin
                        err_run_nxt = '0;
                    end
                end
                default: begin
                    state_nxt    = ST_UNLOCKED;
                    lock_run_nxt = '0;
                    err_run_nxt  = '0;
                end
            endcase
        end
    end

    // Qualifiers use the pre-transition state, so the locking comma itself is not forwarded.
    assign fiber_ok   = (state == ST_LOCKED) && !s1_prbs_en && !s1_marker_en &&
                        ((s1_class == CLS_DATA) || (s1_class == CLS_COMMA));
    assign marker_hit = (state == ST_LOCKED) && !s1_prbs_en && (s1_class == CLS_MARKER);
    assign err_hit    = ((state == ST_LOCKED) || (state == ST_LOCKING)) && !s1_prbs_en &&
                        (s1_class == CLS_ERROR);

    always_ff @(posedge RX_CLK) begin
        if (RESET) begin
            PRBS_DATA    <= '0;
            PRBS_KCHAR   <= '0;
            PRBS_VALID   <= 1'b0;
            FIBER_DATA   <= '0;
            FIBER_KCHAR  <= '0;
            FIBER_VALID  <= 1'b0;
            MARKER_SEEN  <= 1'b0;
            MARKER_DATA  <= '0;
            err_cnt_r    <= '0;
            marker_cnt_r <= '0;
        end else begin
            PRBS_DATA   <= s1_data;
            PRBS_KCHAR  <= s1_kchar;
            PRBS_VALID  <= s1_prbs_en;
            FIBER_DATA  <= s1_data;
            FIBER_KCHAR <= s1_kchar;
            FIBER_VALID <= fiber_ok;
            MARKER_SEEN <= marker_hit;
            if (marker_hit) begin
                MARKER_DATA <= s1_data[15:8];
            end
            if (CLR_CNT) begin
                err_cnt_r <= '0;
            end else if (err_hit && (err_cnt_r != 16'hFFFF)) begin
                err_cnt_r <= err_cnt_r + 16'd1;
            end
            if (CLR_CNT) begin
                marker_cnt_r <= '0;
            end else if (marker_hit && (marker_cnt_r != 16'hFFFF)) begin
                marker_cnt_r <= marker_cnt_r + 16'd1;
            end
        end
    end

    assign LOCKED     = (state == ST_LOCKED);
    assign ERR_CNT    = err_cnt_r;
    assign MARKER_CNT = marker_cnt_r;

endmodule

// File: doc/demux_rx.md
# demux_rx

Receive-side demultiplexer and link qualifier for the loopback/DTC fiber link. It sits between the CorePCS RX word interface and three consumers: the PRBS checker, the loopback marker detector, and the fiber packet receiver. It steers each received 16-bit word and its K-flags to exactly one of these consumers. It also qualifies link lock from comma words and counts marker and error words.

## Interface
Parameters:
- LOCK_CNT, 16: consecutive comma words required to declare lock (range 1..255).
- ERR_LIMIT, 4: consecutive error words in LOCKED that drop lock (range 1..15).

Ports:
- RX_CLK  in  1  recovered RX word clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- RX_DATA  in  16  received word from CorePCS.
- RX_KCHAR  in  2  K-flag per byte; bit0 is the low byte.
- PRBS_EN  in  1  1 = all words go to the PRBS path (highest priority).
- MARKER_EN  in  1  1 = loopback-marker test mode; the fiber path is suppressed.
- CLR_CNT  in  1  synchronous clear of ERR_CNT and MARKER_CNT.
- PRBS_DATA  out  16  registered RX word for the PRBS checker.
- PRBS_KCHAR  out  2  registered K-flags for the PRBS checker.
- PRBS_VALID  out  1  word on PRBS_DATA is valid.
- FIBER_DATA  out  16  data word to the packet receiver.
- FIBER_KCHAR  out  2  K-flags to the packet receiver.
- FIBER_VALID  out  1  word on FIBER_DATA is valid.
- MARKER_SEEN  out  1  one-cycle pulse when a marker word is received.
- MARKER_DATA  out  8  payload byte of the last marker (RX_DATA[15:8]).
- LOCKED  out  1  link qualified.
- ERR_CNT  out  16  saturating count of error words.
- MARKER_CNT  out  16  saturating count of marker words.

## Operation
- Word classes, decoded on the stage-1 registered word:
  - COMMA: KCHAR=2'b01 and DATA[7:0]=8'hBC.
  - MARKER: KCHAR=2'b01 and DATA[7:0]=8'h1C.
  - DATA: KCHAR=2'b00.
  - ERROR: any other combination, i.e. KCHAR[1]=1, or KCHAR=2'b01 with an unknown low byte.
- PRBS path: PRBS_DATA/PRBS_KCHAR always carry the delayed word. PRBS_VALID=PRBS_EN (delayed), independent of lock.
- PRBS_EN=1 behaviour:
  - State is forced to UNLOCKED.
  - FIBER_VALID and MARKER_SEEN are 0.
  - Counters are frozen.
- State machine (PRBS_EN=0):
  - UNLOCKED: COMMA -> LOCKING with lock count=1. Any other class stays in UNLOCKED.
  - LOCKING:
    - COMMA increments the lock count. When the count reaches LOCK_CNT -> LOCKED. With LOCK_CNT=1, the first COMMA goes directly UNLOCKED -> LOCKED.
    - Any non-COMMA word -> UNLOCKED with the count cleared.
  - LOCKED:
    - ERROR increments a consecutive-error count. Reaching ERR_LIMIT -> UNLOCKED.
    - Any non-ERROR word clears the consecutive-error count.
- LOCKED output = (state==LOCKED).
- Fiber path: FIBER_VALID=1 only when all of the following hold: state is LOCKED, PRBS_EN=0, MARKER_EN=0, and class is DATA or COMMA. COMMA words are forwarded so the packet receiver sees idles.
- Marker and error words are never forwarded to the fiber path.
- Markers: when LOCKED and PRBS_EN=0, a MARKER word produces:
  - a MARKER_SEEN pulse;
  - MARKER_DATA updated to DATA[15:8], held until the next marker;
  - a MARKER_CNT increment.
  - This is independent of MARKER_EN.
- ERR_CNT counts ERROR words in LOCKING or LOCKED.
- Counter rules:
  - Both counters saturate at 16'hFFFF.
  - CLR_CNT wins over a simultaneous increment; the result is 0.
- FIBER_DATA/FIBER_KCHAR carry the delayed word regardless of FIBER_VALID.

## Timing
- Two-stage pipeline:
  - Stage 1 registers RX_DATA, RX_KCHAR, PRBS_EN and MARKER_EN.
  - Stage 2 registers all outputs and the next state.
- Latency RX word -> any output is 2 RX_CLK cycles.
- LOCKED rises on the same edge that outputs the LOCK_CNT-th comma. That comma itself has FIBER_VALID=0.
- LOCKED falls on the edge that outputs the ERR_LIMIT-th consecutive error.
- PRBS_EN/MARKER_EN changes take effect on the word entering stage 1 in the same cycle, i.e. they appear at the outputs 2 cycles later.
- Reset:
  - All outputs are 0, the state is UNLOCKED, and all internal counts are 0 on the cycle after RESET is sampled high.
  - The pipeline is flushed, so no word received before or during RESET produces VALID/SEEN.
  - Reset mid-packet simply drops the packet.

## Structure
- Shared package rx_link_pkg holds:
  - constants K28_5_COMMA=8'hBC and K28_0_MARKER=8'h1C;
  - the word-class enum {COMMA, MARKER, DATA, ERROR};
  - the state enum {UNLOCKED, LOCKING, LOCKED}.
- The TX marker generator imports the same package.
- One natural sub-module: rx_word_classify, a stage-1 register plus class decode. Counters and the FSM stay in the top module.

## Test plan
- Lock acquisition: reset, then 16 commas (16'h50BC, K=2'b01) -> LOCKED=1 exactly 2 cycles after the 16th comma is presented. A DATA word 16'h1234 following it -> FIBER_DATA=16'h1234, FIBER_VALID=1.
- Lock abort: 10 commas, then 16'h0000 with K=2'b00 -> remains unlocked. A following 16 commas lock.
- Lock loss: LOCKED, then 3 error words (K=2'b10), 1 data word, 4 error words -> LOCKED drops only after the 4th consecutive error. ERR_CNT=7.
- Marker: LOCKED, MARKER_EN=1, word 16'hA51C K=2'b01 -> MARKER_SEEN pulse for 1 cycle, MARKER_DATA=8'hA5, MARKER_CNT=1. FIBER_VALID stays 0 throughout.
- PRBS priority: LOCKED, assert PRBS_EN with MARKER_EN=1 -> PRBS_VALID=1 and LOCKED=0 two cycles later. Markers are ignored and the counters do not move.
- Counters/reset: force ERR_CNT to 16'hFFFF, add one more error -> it holds 16'hFFFF. CLR_CNT together with an error -> 0. RESET mid-packet -> all outputs 0 next cycle.
